// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// then clocks out start/data/parity/stop on device clock edges and checks the ack.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       clk_ps2,
  input  logic       data_ps2,
  output logic       clk_ps2_oe,
  output logic       data_ps2_oe,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic          clk_s, data_s, fall;
  logic [7:0]    shift_q, shift_n;
  logic          parity_q, parity_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [IW-1:0] inh_cnt, inh_cnt_n, inh_inc;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          to_hit;
  logic          clk_oe_n, data_oe_n, done_n, err_n;

  assign clk_s    = clk_sync[1];
  assign data_s   = data_sync[1];
  assign fall     = clk_prev & ~clk_s;
  assign to_hit   = (to_cnt == TO_LAST);
  assign inh_inc  = inh_cnt + 1'b1;
  assign tx_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], clk_ps2};
      data_sync <= {data_sync[0], data_ps2};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      clk_ps2_oe  <= 1'b0;
      data_ps2_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      state       <= state_n;
      shift_q     <= shift_n;
      parity_q    <= parity_n;
      bit_cnt     <= bit_cnt_n;
      inh_cnt     <= inh_cnt_n;
      to_cnt      <= to_cnt_n;
      clk_ps2_oe  <= clk_oe_n;
      data_ps2_oe <= data_oe_n;
      tx_done     <= done_n;
      tx_err      <= err_n;
    end
  end

  // Line drives are computed one cycle ahead so the oe outputs come straight from flops.
  always_comb begin
    state_n   = state;
    shift_n   = shift_q;
    parity_n  = parity_q;
    bit_cnt_n = bit_cnt;
    inh_cnt_n = inh_cnt;
    to_cnt_n  = to_cnt;
    clk_oe_n  = clk_ps2_oe;
    data_oe_n = data_ps2_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;

    case (state)
      IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid) begin
          shift_n   = tx_data;
          parity_n  = ~^tx_data;
          bit_cnt_n = '0;
          inh_cnt_n = '0;
          to_cnt_n  = '0;
          clk_oe_n  = 1'b1;
          data_oe_n = (INH_LAST == '0);
          state_n   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          to_cnt_n  = '0;
          state_n   = REQUEST;
        end else begin
          inh_cnt_n = inh_inc;
          clk_oe_n  = 1'b1;
          data_oe_n = (inh_inc == INH_LAST);
        end
      end

      REQUEST: begin
        to_cnt_n = to_cnt + 1'b1;
        if (fall) begin
          to_cnt_n  = '0;
          data_oe_n = ~shift_q[0];
          bit_cnt_n = 4'd1;
          state_n   = SEND;
        end else if (to_hit) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          err_n     = 1'b1;
          state_n   = IDLE;
        end
      end

      SEND: begin
        to_cnt_n = to_cnt + 1'b1;
        if (fall) begin
          to_cnt_n  = '0;
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt < 4'd8) begin
            data_oe_n = ~shift_q[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            data_oe_n = ~parity_q;
          end else begin
            data_oe_n = 1'b0;
            state_n   = ACK;
          end
        end else if (to_hit) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          err_n     = 1'b1;
          state_n   = IDLE;
        end
      end

      ACK: begin
        to_cnt_n  = to_cnt + 1'b1;
        data_oe_n = 1'b0;
        if (fall) begin
          to_cnt_n = '0;
          if (data_s) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_IDLE;
          end
        end else if (to_hit) begin
          clk_oe_n = 1'b0;
          err_n    = 1'b1;
          state_n  = IDLE;
        end
      end

      WAIT_IDLE: begin
        to_cnt_n = to_cnt + 1'b1;
        if (clk_s && data_s) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          to_cnt_n = '0;
        end else if (to_hit) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          err_n     = 1'b1;
          state_n   = IDLE;
        end
      end

      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with an open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       clk_ps2, data_ps2;
  logic       clk_ps2_oe, data_ps2_oe;
  logic       tx_done, tx_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign clk_ps2  = ~(clk_ps2_oe | dev_clk_low);
  assign data_ps2 = ~(data_ps2_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .clk_ps2     (clk_ps2),
    .data_ps2    (data_ps2),
    .clk_ps2_oe  (clk_ps2_oe),
    .data_ps2_oe (data_ps2_oe),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0, done_cyc = 0, err_cyc = 0, release_cyc = 0;
  bit exp_resp[$];  // 0 = tx_done expected, 1 = tx_err expected

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Response monitor and inhibit-phase checker
  int inh_len = 0, inh_d = 0;
  logic inh_last = 1'b0, prev_oe = 1'b0, pend = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      inh_len = 0; inh_d = 0; inh_last = 1'b0; prev_oe = 1'b0; pend = 1'b0;
    end else begin
      if (pend) begin
        chk("ready_after_pulse", tx_ready, 1);
        pend = 1'b0;
      end
      if (tx_done || tx_err) begin
        chk("done_err_exclusive", tx_done & tx_err, 0);
        chk("oe_released_at_pulse", {clk_ps2_oe, data_ps2_oe}, 0);
        if (exp_resp.size() == 0)
          chk("unexpected_pulse", {tx_done, tx_err}, 0);
        else
          chk("response_kind", {tx_done, tx_err}, exp_resp.pop_front() ? 2'b01 : 2'b10);
        if (tx_done) done_cyc = cyc;
        else err_cyc = cyc;
        pend = 1'b1;
      end
      if (clk_ps2_oe) begin
        inh_len++;
        if (data_ps2_oe) inh_d++;
        inh_last = data_ps2_oe;
      end else if (prev_oe) begin
        chk("inhibit_len", inh_len, INH);
        chk("inhibit_data_cycles", inh_d, 1);
        chk("inhibit_data_last", inh_last, 1);
        req_cyc = cyc;
        inh_len = 0; inh_d = 0;
      end
      prev_oe = clk_ps2_oe;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 3000) begin @(negedge clk); n++; end
    chk("send_ready_wait", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (exp_resp.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk("resp_wait", exp_resp.size(), 0);
    @(negedge clk);
  endtask

  // Device: samples each bit mid-high, then drives the falling edge.
  task automatic dev_frame(input logic ack, input int abort_edge, input int hold_cyc,
                           input logic [10:0] exp, input logic do_chk);
    logic [10:0] got;
    int n;
    got = '0;
    n = 0;
    while (!clk_ps2_oe && n < 200) begin @(posedge clk); n++; end
    chk("dev_saw_inhibit", clk_ps2_oe, 1);
    n = 0;
    while (clk_ps2_oe && n < 200) begin @(posedge clk); n++; end
    chk("dev_saw_request", data_ps2, 0);
    #100;
    for (int k = 1; k <= 11; k++) begin
      #50;
      got[k-1] = data_ps2;
      if (k == 11 && ack) dev_data_low = 1'b1;
      #50;
      dev_clk_low = 1'b1;
      if (k == abort_edge) begin
        #60;
        return;
      end
      #100;
      if (k == 11) begin
        repeat (hold_cyc) @(posedge clk);
        release_cyc = cyc;
      end
      dev_clk_low = 1'b0;
    end
    #50;
    dev_data_low = 1'b0;
    if (do_chk) chk("frame_bits", got, exp);
  endtask

  initial begin
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", clk_ps2_oe, 0);
    chk("rst_data_oe", data_ps2_oe, 0);
    chk("rst_pulses", {tx_done, tx_err}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", tx_ready, 1);

    // 8'h1D acked: start 0, d0..d7 1,0,1,1,1,0,0,0, parity 1, stop 1
    exp_resp.push_back(1'b0);
    send_byte(8'h1D);
    dev_frame(1'b1, 0, 0, 11'h63A, 1'b1);
    wait_resp();

    // 8'h00 without ack: parity 1, tx_err
    exp_resp.push_back(1'b1);
    send_byte(8'h00);
    dev_frame(1'b0, 0, 0, 11'h600, 1'b1);
    wait_resp();

    // Silent device: timeout counted from REQUEST entry
    exp_resp.push_back(1'b1);
    send_byte(8'h5A);
    wait_resp();
    chk("timeout_latency", err_cyc - req_cyc, TO);
    chk("timeout_lines_idle", {clk_ps2_oe, data_ps2_oe}, 0);

    // Reset while d4 of 8'hA5 (a 0) is on the line
    send_byte(8'hA5);
    dev_frame(1'b1, 5, 0, '0, 1'b0);
    chk("d4_driven_low", data_ps2_oe, 1);
    rst = 1'b1;
    #1;
    chk("midframe_rst_oe", {clk_ps2_oe, data_ps2_oe}, 0);
    chk("midframe_rst_pulses", {tx_done, tx_err}, 0);
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_midframe_rst", tx_ready, 1);
    exp_resp.push_back(1'b0);
    send_byte(8'h3C);
    dev_frame(1'b1, 0, 0, 11'h678, 1'b1);
    wait_resp();

    // Requests while busy are dropped
    exp_resp.push_back(1'b0);
    fork
      dev_frame(1'b1, 0, 0, 11'h63A, 1'b1);
      begin
        send_byte(8'h1D);
        repeat (30) @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (100) @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_resp();
    repeat (40) @(negedge clk);
    chk("no_extra_frame", {clk_ps2_oe, tx_ready}, 2'b01);

    // Device holds clock low after ack: done waits for release
    exp_resp.push_back(1'b0);
    send_byte(8'h1D);
    dev_frame(1'b1, 0, 40, 11'h63A, 1'b1);
    wait_resp();
    chk("done_after_clk_release", done_cyc > release_cyc, 1);

    // Held beyond the timeout: tx_err while still held
    exp_resp.push_back(1'b1);
    send_byte(8'h1D);
    dev_frame(1'b1, 0, 1100, 11'h63A, 1'b1);
    wait_resp();
    chk("err_during_hold", err_cyc < release_cyc, 1);

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
